adder_pipe_nbit: RTL and testbench
==================================

// Module: adder_pipe_nbit
//
// PURPOSE
// - Parametrised pipelined ripple-chunk adder. Computes {cout,sum} = a + b + cin for WIDTH-bit operands.
// - Splits the operands into CHUNK-bit slices and adds one slice per pipeline stage, passing the carry
//   forward one stage per cycle.
// - Uses a valid/ready handshake on both sides and sits between datapath producers and consumers.
// - Replaces fixed-width combinational ripple adders on timing-critical wide datapaths.
//
// PARAMETERS
// - WIDTH  32  operand/sum width in bits; must be a multiple of CHUNK, >= CHUNK
// - CHUNK   8  bits added per pipeline stage; STAGES = WIDTH/CHUNK (derived localparam)
//
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      synchronous active-high reset
// - in_valid   in   1      a, b, cin valid this cycle
// - in_ready   out  1      block accepts an operand set this cycle
// - a          in   WIDTH  operand A (unsigned bits; signed view used only for ovf)
// - b          in   WIDTH  operand B
// - cin        in   1      carry into bit 0
// - out_valid  out  1      sum/cout hold a valid result
// - out_ready  in   1      consumer accepts the result this cycle
// - sum        out  WIDTH  result bits [WIDTH-1:0]
// - cout       out  1      carry out of bit WIDTH-1
// - ovf        out  1      signed overflow; present only with ADDER_PIPE_OVF_EN
//
// BEHAVIOUR
// - Reset: all stage valid bits are cleared. out_valid=0, sum=0, cout=0, ovf=0.
//   in_ready=1 in the first cycle after reset.
// - Reset mid-operation discards all in-flight results; no partial result is emitted.
// - Global advance: adv = !out_valid | out_ready. in_ready = adv (combinational).
//   - The whole pipe shifts one stage when adv=1.
//   - When adv=0, every stage register holds its value, including its valid bit and payload.
// - Accept: a transfer occurs when in_valid & in_ready; it loads stage 0.
//   - If adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
// - Stage k (0..STAGES-1):
//   - Adds slice a[k*CHUNK+:CHUNK] + b[k*CHUNK+:CHUNK] + carry_in.
//   - carry_in is cin for k=0, otherwise the registered carry from stage k-1.
//   - The upper unprocessed slices of a and b travel with the data.
//   - Already-computed low sum slices travel with the data.
// - Latency: a result accepted in cycle t appears with out_valid=1 in cycle t+STAGES when never stalled.
// - Throughput: one result per cycle while out_ready=1.
// - Arithmetic: modulo 2^WIDTH. cout is the carry of the full WIDTH-bit add; no saturation.
// - Simultaneous events:
//   - out_valid & out_ready & in_valid: the output drains and a new input is accepted in the same cycle.
//   - Results stay in order.
// - Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf stay constant.
// - Bubbles: a valid result never overtakes an earlier one. Bubbles are not compressed.
// - STAGES=1 (CHUNK=WIDTH) degenerates to a single registered adder with latency 1.
//
// CONFIGURATION
// - Macro ADDER_PIPE_OVF_EN.
// - Defined:
//   - Port ovf exists.
//   - ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]), evaluated in the last stage.
//   - The operand MSBs are carried down the pipe to evaluate it.
//   - ovf has the same timing and hold rules as sum.
// - Undefined: port ovf and its MSB carry registers are absent. All other behaviour is identical.
//
// TESTING (WIDTH=32, CHUNK=8 unless noted)
// - Reset: assert rst for 2 cycles mid-stream with 3 results in flight.
//   - Required: out_valid=0 and sum=0 the next cycle.
//   - Required: no stale result emerges afterwards.
// - Full carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1, out_ready=1.
//   - Required: after 4 cycles, sum=0x00000000, cout=1.
// - Back-to-back: 0x12345678+0x11111111 (cin=0), then 0x80000000+0x80000000 (cin=0), then 1+2 (cin=1).
//   - Required: consecutive outputs 0x23456789/cout0, 0x00000000/cout1, 0x00000004/cout0.
// - Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
//   - Required: in_ready=0 once out_valid=1.
//   - Required: sum held constant; no input lost or duplicated; 4 results drain in order on release.
// - ADDER_PIPE_OVF_EN: 0x7FFFFFFF+1 -> sum=0x80000000, ovf=1, cout=0.
//   - 0xFFFFFFFF+1 -> ovf=0, cout=1.
// - Parameter sweep: WIDTH/CHUNK = 8/8, 16/4, 64/16.
//   - Stimulus: 1000 random vectors against a reference model.
//   - Required: results match the model; latency = STAGES.

Source files
------------

// File: rtl/adder_pipe_nbit.sv
// Pipelined ripple-chunk adder: {cout,sum} = a + b + cin, one CHUNK-bit slice per stage.
// Define ADDER_PIPE_OVF_EN to add the signed-overflow output ovf.
module adder_pipe_nbit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int STAGES = WIDTH / CHUNK;

  // Handshake: a word moves across a boundary when valid & ready are both high there.
  // The pipe shifts as one unit whenever the output slot is empty or being drained
  // (adv); in_ready is adv, so a stalled output freezes every stage, bubbles included.
  logic adv;

  logic             v_w [STAGES];
  logic             c_w [STAGES];
  logic [WIDTH-1:0] a_w [STAGES];
  logic [WIDTH-1:0] b_w [STAGES];
  logic [WIDTH-1:0] s_w [STAGES];
`ifdef ADDER_PIPE_OVF_EN
  logic             am_w [STAGES];
  logic             bm_w [STAGES];
`endif

  assign out_valid = v_w[STAGES-1];
  assign sum       = s_w[STAGES-1];
  assign cout      = c_w[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_src;
    logic             c_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic [WIDTH-1:0] s_nxt;
    logic [CHUNK:0]   slice;

    logic             v_r;
    logic             c_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;

    if (k == 0) begin : g_head
      assign v_src = in_valid;
      assign c_src = cin;
      assign a_src = a;
      assign b_src = b;
      assign s_src = '0;
    end else begin : g_body
      assign v_src = v_w[k-1];
      assign c_src = c_w[k-1];
      assign a_src = a_w[k-1];
      assign b_src = b_w[k-1];
      assign s_src = s_w[k-1];
    end

    assign slice = {1'b0, a_src[k*CHUNK +: CHUNK]}
                 + {1'b0, b_src[k*CHUNK +: CHUNK]}
                 + (CHUNK+1)'(c_src);

    // Low slices already summed ride along; this stage fills in its own slice.
    always_comb begin
      s_nxt = s_src;
      s_nxt[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        a_r <= '0;
        b_r <= '0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= v_src;
        c_r <= slice[CHUNK];
        a_r <= a_src;
        b_r <= b_src;
        s_r <= s_nxt;
      end
    end

    assign v_w[k] = v_r;
    assign c_w[k] = c_r;
    assign a_w[k] = a_r;
    assign b_w[k] = b_r;
    assign s_w[k] = s_r;

`ifdef ADDER_PIPE_OVF_EN
    logic am_src;
    logic bm_src;
    logic am_r;
    logic bm_r;

    if (k == 0) begin : g_msb_head
      assign am_src = a[WIDTH-1];
      assign bm_src = b[WIDTH-1];
    end else begin : g_msb_body
      assign am_src = am_w[k-1];
      assign bm_src = bm_w[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        am_r <= 1'b0;
        bm_r <= 1'b0;
      end else if (adv) begin
        am_r <= am_src;
        bm_r <= bm_src;
      end
    end

    assign am_w[k] = am_r;
    assign bm_w[k] = bm_r;

    // Overflow needs the final MSB, so only the last stage evaluates and holds it.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (adv) begin
          ovf_r <= (am_src == bm_src) && (s_nxt[WIDTH-1] != am_src);
        end
      end
      assign ovf = ovf_r;
    end
`endif
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: directed table at 32/8 plus randomized sweeps at 16/4 and 8/8.
module tb_adder_pipe_nbit;
  localparam int W   = 32;
  localparam int STG = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef ADDER_PIPE_OVF_EN
  logic         ovf;
`endif

  adder_pipe_nbit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model32(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return {(x[W-1] == y[W-1]) && (r[W-1] != x[W-1]), r[W], r[W-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}
  int           acc_q[$];
  bit           lat_chk = 1'b0;
  int           n_out = 0;
  logic [W+1:0] e;
  int           t_acc;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(sum), 64'hDEAD);
      end else begin
        e     = exp_q.pop_front();
        t_acc = acc_q.pop_front();
        check("sum", 64'(sum), 64'(e[W-1:0]));
        check("cout", 64'(cout), 64'(e[W]));
`ifdef ADDER_PIPE_OVF_EN
        check("ovf", 64'(ovf), 64'(e[W+1]));
`endif
        if (lat_chk) check("latency", 64'(cyc - t_acc), 64'(STG));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                      input logic [W+1:0] ex);
    bit ok;
    ok = 1'b0;
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ex);
        acc_q.push_back(cyc);
        ok = 1'b1;
      end
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t tbl[12];

  // ---------------- sweep 16/4 ----------------
  localparam int XW = 16;
  localparam int XS = 4;
  logic          x_rst, x_iv, x_ir, x_ci, x_ov, x_or, x_co;
  logic [XW-1:0] x_a, x_b, x_s;
`ifdef ADDER_PIPE_OVF_EN
  logic          x_ovf;
`endif
  bit            x_done = 1'b0;

  adder_pipe_nbit #(.WIDTH(XW), .CHUNK(4)) dut_x (
    .clk(clk), .rst(x_rst), .in_valid(x_iv), .in_ready(x_ir),
    .a(x_a), .b(x_b), .cin(x_ci), .out_valid(x_ov), .out_ready(x_or),
    .sum(x_s), .cout(x_co)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(x_ovf)
`endif
  );

  initial begin
    logic [XW+1:0] xq[$];
    int            xt[$];
    logic [XW+1:0] xe;
    logic [XW:0]   r;
    int            tt;
    x_rst = 1'b1; x_iv = 1'b0; x_or = 1'b1; x_a = '0; x_b = '0; x_ci = 1'b0;
    repeat (3) tick();
    x_rst = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      x_a  = XW'($urandom);
      x_b  = XW'($urandom);
      x_ci = 1'($urandom_range(0, 1));
      x_iv = (i < 1280) && ($urandom_range(0, 3) != 0);
      x_or = (i < 500 || i >= 1280) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (x_ov && x_or) begin
        if (xq.size() == 0) begin
          check("x_unexpected", 64'(x_s), 64'hDEAD);
        end else begin
          xe = xq.pop_front();
          tt = xt.pop_front();
          check("x_sum", 64'(x_s), 64'(xe[XW-1:0]));
          check("x_cout", 64'(x_co), 64'(xe[XW]));
`ifdef ADDER_PIPE_OVF_EN
          check("x_ovf", 64'(x_ovf), 64'(xe[XW+1]));
`endif
          if (i < 500) check("x_latency", 64'(cyc - tt), 64'(XS));
        end
      end
      if (x_iv && x_ir) begin
        r = {1'b0, x_a} + {1'b0, x_b} + {{XW{1'b0}}, x_ci};
        xq.push_back({(x_a[XW-1] == x_b[XW-1]) && (r[XW-1] != x_a[XW-1]), r});
        xt.push_back(cyc);
      end
      tick();
    end
    check("x_left", 64'(xq.size()), 64'd0);
    x_done = 1'b1;
  end

  // ---------------- sweep 8/8 (single stage) ----------------
  localparam int YW = 8;
  logic          y_rst, y_iv, y_ir, y_ci, y_ov, y_or, y_co;
  logic [YW-1:0] y_a, y_b, y_s;
`ifdef ADDER_PIPE_OVF_EN
  logic          y_ovf;
`endif
  bit            y_done = 1'b0;

  adder_pipe_nbit #(.WIDTH(YW), .CHUNK(8)) dut_y (
    .clk(clk), .rst(y_rst), .in_valid(y_iv), .in_ready(y_ir),
    .a(y_a), .b(y_b), .cin(y_ci), .out_valid(y_ov), .out_ready(y_or),
    .sum(y_s), .cout(y_co)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(y_ovf)
`endif
  );

  initial begin
    logic [YW+1:0] yq[$];
    int            yt[$];
    logic [YW+1:0] ye;
    logic [YW:0]   r;
    int            tt;
    y_rst = 1'b1; y_iv = 1'b0; y_or = 1'b1; y_a = '0; y_b = '0; y_ci = 1'b0;
    repeat (3) tick();
    y_rst = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      y_a  = YW'($urandom);
      y_b  = YW'($urandom);
      y_ci = 1'($urandom_range(0, 1));
      y_iv = (i < 1090) && ($urandom_range(0, 4) != 0);
      y_or = (i < 400 || i >= 1090) ? 1'b1 : ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (y_ov && y_or) begin
        if (yq.size() == 0) begin
          check("y_unexpected", 64'(y_s), 64'hDEAD);
        end else begin
          ye = yq.pop_front();
          tt = yt.pop_front();
          check("y_sum", 64'(y_s), 64'(ye[YW-1:0]));
          check("y_cout", 64'(y_co), 64'(ye[YW]));
`ifdef ADDER_PIPE_OVF_EN
          check("y_ovf", 64'(y_ovf), 64'(ye[YW+1]));
`endif
          if (i < 400) check("y_latency", 64'(cyc - tt), 64'd1);
        end
      end
      if (y_iv && y_ir) begin
        r = {1'b0, y_a} + {1'b0, y_b} + {{YW{1'b0}}, y_ci};
        yq.push_back({(y_a[YW-1] == y_b[YW-1]) && (r[YW-1] != y_a[YW-1]), r});
        yt.push_back(cyc);
      end
      tick();
    end
    check("y_left", 64'(yq.size()), 64'd0);
    y_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int            k;
    int            n_before;
    logic [W+1:0]  m;

    tbl[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[1]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    tbl[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[3]  = '{32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0};
    tbl[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[5]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[7]  = '{32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0};
    tbl[8]  = '{32'h00FFFF00, 32'h00000100, 1'b0, 32'h01000000, 1'b0, 1'b0};
    tbl[9]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[10] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h0001FFFE, 1'b0, 1'b0};
    tbl[11] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ADDER_PIPE_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    tick();

    // isolated vectors, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].ci, {tbl[i].o, tbl[i].c, tbl[i].s});
      wait_drain();
    end

    // back-to-back triple
    send(32'h12345678, 32'h11111111, 1'b0, {1'b0, 1'b0, 32'h23456789});
    send(32'h80000000, 32'h80000000, 1'b0, {1'b1, 1'b1, 32'h00000000});
    send(32'h00000001, 32'h00000002, 1'b1, {1'b0, 1'b0, 32'h00000004});
    wait_drain();

    // whole table streamed
    for (int i = 0; i < 12; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].ci, {tbl[i].o, tbl[i].c, tbl[i].s});
    wait_drain();

    // backpressure: out_ready low while producer keeps offering
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    n_before  = n_out;
    k = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a = 32'h01010101 * (k + 1); b = 32'h10F0E0D0; cin = 1'(k);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model32(a, b, cin));
        acc_q.push_back(cyc);
        k++;
      end
      if (i >= 4) begin
        m = model32(32'h01010101, 32'h10F0E0D0, 1'b0);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_sum_held", 64'(sum), 64'(m[W-1:0]));
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(k), 64'd4);
    out_ready = 1'b1;
    wait_drain();
    check("bp_drained", 64'(n_out - n_before), 64'd4);

    // reset with three results in flight
    send(32'h11111111, 32'h22222222, 1'b0, model32(32'h11111111, 32'h22222222, 1'b0));
    send(32'h33333333, 32'h44444444, 1'b1, model32(32'h33333333, 32'h44444444, 1'b1));
    send(32'h55555555, 32'h66666666, 1'b0, model32(32'h55555555, 32'h66666666, 1'b0));
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    n_before = n_out;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(negedge clk);
    check("mid_rst_no_stale", 64'(n_out - n_before), 64'd0);
    tick();
    lat_chk = 1'b1;
    send(32'hDEADBEEF, 32'h01234567, 1'b1, model32(32'hDEADBEEF, 32'h01234567, 1'b1));
    wait_drain();

    for (int i = 0; i < 5000 && !(x_done && y_done); i++) @(negedge clk);
    check("sweeps_done", 64'(x_done && y_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
